mem_port_arbiter: RTL and testbench

- Shares the core's single memory bus between instruction fetch and data load/store, the data path driven by the datapath controller's memRdEnable/memWrEnable/memAccess.
- Per-port request/ready handshake, fixed data priority with anti-starvation, byte-lane generation and read alignment.
- Sits between the fetch/LSU stages and the external memory interface.

---
 rtl/mem_port_arbiter.sv | 168 ++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Shares one memory bus between instruction fetch and data load/store, data has priority with anti-starvation.
// Latency: request to o_memReq 1 cycle; i_memAck to ready pulse 1 cycle; misaligned data errors return in 1 cycle.
// Backpressure: requesters hold req until their ready pulse; the bus request is held until i_memAck.
module mem_port_arbiter #(
  parameter int unsigned MAX_DATA_BURST = 4
) (
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic        i_instReq,
  input  logic [31:0] i_instAddr,
  output logic        o_instReady,
  output logic [31:0] o_instData,
  input  logic        i_dataReq,
  input  logic        i_dataWrEnable,
  input  logic [1:0]  i_dataAccess,
  input  logic [31:0] i_dataAddr,
  input  logic [31:0] i_dataWrData,
  output logic        o_dataReady,
  output logic [31:0] o_dataRdData,
  output logic        o_dataError,
  output logic        o_memReq,
  output logic        o_memWrEnable,
  output logic [31:0] o_memAddr,
  output logic [3:0]  o_memByteEnable,
  output logic [31:0] o_memWrData,
  input  logic        i_memAck,
  input  logic [31:0] i_memRdData
);

  localparam logic [3:0] BURST_LIMIT = 4'(MAX_DATA_BURST);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUS_I = 2'd1,
    BUS_D = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t      state;
  logic [3:0]  burst_cnt;
  logic [1:0]  rd_off;      // byte offset of the load in flight, used to right-align read data
  logic        data_wins;
  logic        data_err;
  logic [3:0]  data_be;
  logic [31:0] data_wdat;
  logic [1:0]  unused_inst_lsb;

  // Fetches are always whole aligned words, so the low address bits carry no information.
  assign unused_inst_lsb = i_instAddr[1:0];

  // Arbitration decision and data-side lane decode, evaluated from the live request inputs.
  always_comb begin
    data_wins = i_dataReq && (!i_instReq || (burst_cnt < BURST_LIMIT));
    data_err  = 1'b0;
    data_be   = 4'b1111;
    data_wdat = i_dataWrData;
    case (i_dataAccess)
      2'b00: begin
        data_be   = 4'b0001 << i_dataAddr[1:0];
        data_wdat = {4{i_dataWrData[7:0]}};
      end
      2'b01: begin
        data_be   = 4'b0011 << i_dataAddr[1:0];
        data_wdat = {2{i_dataWrData[15:0]}};
        data_err  = i_dataAddr[0];
      end
      2'b10: begin
        data_be   = 4'b1111;
        data_wdat = i_dataWrData;
        data_err  = (i_dataAddr[1:0] != 2'b00);
      end
      default: begin
        data_err  = 1'b1;
      end
    endcase
  end

  // Anti-starvation counter: counts data grants taken while a fetch is waiting.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      burst_cnt <= 4'd0;
    end else if (!i_instReq) begin
      burst_cnt <= 4'd0;
    end else if (state == IDLE) begin
      if (data_wins) begin
        burst_cnt <= burst_cnt + 4'd1;
      end else begin
        burst_cnt <= 4'd0;
      end
    end
  end

  // Transaction FSM; all bus and response outputs are registered here.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state           <= IDLE;
      rd_off          <= 2'b00;
      o_instReady     <= 1'b0;
      o_instData      <= 32'd0;
      o_dataReady     <= 1'b0;
      o_dataRdData    <= 32'd0;
      o_dataError     <= 1'b0;
      o_memReq        <= 1'b0;
      o_memWrEnable   <= 1'b0;
      o_memAddr       <= 32'd0;
      o_memByteEnable <= 4'd0;
      o_memWrData     <= 32'd0;
    end else begin
      o_instReady <= 1'b0;
      o_dataReady <= 1'b0;
      o_dataError <= 1'b0;
      case (state)
        IDLE: begin
          if (data_wins) begin
            if (data_err) begin
              // Bad alignment or access code: answer straight away without touching the bus.
              state        <= RESP;
              o_dataReady  <= 1'b1;
              o_dataError  <= 1'b1;
              o_dataRdData <= 32'd0;
            end else begin
              state           <= BUS_D;
              o_memReq        <= 1'b1;
              o_memWrEnable   <= i_dataWrEnable;
              o_memAddr       <= {i_dataAddr[31:2], 2'b00};
              o_memByteEnable <= data_be;
              o_memWrData     <= data_wdat;
              rd_off          <= i_dataAddr[1:0];
            end
          end else if (i_instReq) begin
            state           <= BUS_I;
            o_memReq        <= 1'b1;
            o_memWrEnable   <= 1'b0;
            o_memAddr       <= {i_instAddr[31:2], 2'b00};
            o_memByteEnable <= 4'b1111;
            o_memWrData     <= 32'd0;
          end
        end
        BUS_I: begin
          if (i_memAck) begin
            state       <= RESP;
            o_memReq    <= 1'b0;
            o_instData  <= i_memRdData;
            o_instReady <= 1'b1;
          end
        end
        BUS_D: begin
          if (i_memAck) begin
            state       <= RESP;
            o_memReq    <= 1'b0;
            o_dataReady <= 1'b1;
            if (!o_memWrEnable) begin
              o_dataRdData <= i_memRdData >> {rd_off, 3'b000};
            end
          end
        end
        RESP: begin
          // The served requester still holds req this cycle, so nothing is sampled here.
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: fetch, data lanes, errors, burst fairness and reset abort.
// Inputs are driven 1 time unit after the rising edge; outputs are sampled on the falling edge.
// Summary line reports the number of comparisons and the number that failed.
module tb_mem_port_arbiter;

  logic        clk;
  logic        rst;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_ready;
  logic [31:0] inst_data;
  logic        data_req;
  logic        data_wr;
  logic [1:0]  data_acc;
  logic [31:0] data_addr;
  logic [31:0] data_wdat;
  logic        data_ready;
  logic [31:0] data_rdat;
  logic        data_error;
  logic        mem_req;
  logic        mem_wr;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdat;
  logic        mem_ack;
  logic [31:0] mem_rdat;

  int checks = 0;
  int errors = 0;

  mem_port_arbiter #(.MAX_DATA_BURST(4)) dut (
    .i_clock         (clk),
    .i_reset         (rst),
    .i_instReq       (inst_req),
    .i_instAddr      (inst_addr),
    .o_instReady     (inst_ready),
    .o_instData      (inst_data),
    .i_dataReq       (data_req),
    .i_dataWrEnable  (data_wr),
    .i_dataAccess    (data_acc),
    .i_dataAddr      (data_addr),
    .i_dataWrData    (data_wdat),
    .o_dataReady     (data_ready),
    .o_dataRdData    (data_rdat),
    .o_dataError     (data_error),
    .o_memReq        (mem_req),
    .o_memWrEnable   (mem_wr),
    .o_memAddr       (mem_addr),
    .o_memByteEnable (mem_be),
    .o_memWrData     (mem_wdat),
    .i_memAck        (mem_ack),
    .i_memRdData     (mem_rdat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    rst = 1'b1;
    inst_req = 1'b0; inst_addr = 32'd0;
    data_req = 1'b0; data_wr = 1'b0; data_acc = 2'b00; data_addr = 32'd0; data_wdat = 32'd0;
    mem_ack = 1'b0; mem_rdat = 32'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({mem_req, mem_wr, inst_ready, data_ready, data_error} !== 5'b0 || mem_addr !== 32'd0 ||
        mem_be !== 4'd0 || mem_wdat !== 32'd0 || inst_data !== 32'd0 || data_rdat !== 32'd0) begin
      errors++;
      $display("FAIL reset_outputs: req=%b wr=%b addr=%h be=%b wdat=%h idat=%h drdat=%h", mem_req, mem_wr,
               mem_addr, mem_be, mem_wdat, inst_data, data_rdat);
    end
    @(posedge clk); #1 rst = 1'b0;
  endtask

  task automatic test_inst_fetch(input logic [31:0] addr, input logic [31:0] rdat, input logic [31:0] exp_addr);
    @(posedge clk); #1 inst_req = 1'b1; inst_addr = addr;
    @(negedge clk);
    checks++;
    if (mem_req !== 1'b0) begin errors++; $display("FAIL fetch_early_req: got %b want 0", mem_req); end
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== exp_addr || mem_be !== 4'b1111 || mem_wr !== 1'b0) begin
      errors++;
      $display("FAIL fetch_bus: req=%b addr=%h be=%b wr=%b want 1 %h 1111 0", mem_req, mem_addr, mem_be, mem_wr, exp_addr);
    end
    @(posedge clk); #1 mem_ack = 1'b1; mem_rdat = rdat;
    @(negedge clk);
    checks++;
    if (inst_ready !== 1'b0) begin errors++; $display("FAIL fetch_ready_early: got %b want 0", inst_ready); end
    @(posedge clk); #1 mem_ack = 1'b0; inst_req = 1'b0; mem_rdat = 32'h0;
    @(negedge clk);
    checks++;
    if (inst_ready !== 1'b1 || inst_data !== rdat || mem_req !== 1'b0 || data_ready !== 1'b0) begin
      errors++;
      $display("FAIL fetch_ready: ready=%b data=%h req=%b dready=%b want 1 %h 0 0", inst_ready, inst_data, mem_req, data_ready, rdat);
    end
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (inst_ready !== 1'b0 || inst_data !== rdat) begin
      errors++;
      $display("FAIL fetch_hold: ready=%b data=%h want 0 %h", inst_ready, inst_data, rdat);
    end
  endtask

  task automatic test_data_access(input string name, input logic wr, input logic [1:0] acc,
                                  input logic [31:0] addr, input logic [31:0] wdat, input logic [31:0] bus_rd,
                                  input logic [3:0] exp_be, input logic [31:0] exp_wdat, input logic [31:0] exp_rd);
    @(posedge clk); #1 data_req = 1'b1; data_wr = wr; data_acc = acc; data_addr = addr; data_wdat = wdat;
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (mem_req !== 1'b1 || mem_wr !== wr || mem_addr !== {addr[31:2], 2'b00} || mem_be !== exp_be ||
        (wr && mem_wdat !== exp_wdat)) begin
      errors++;
      $display("FAIL %s_bus: req=%b wr=%b addr=%h be=%b wdat=%h want 1 %b %h %b %h", name, mem_req, mem_wr,
               mem_addr, mem_be, mem_wdat, wr, {addr[31:2], 2'b00}, exp_be, exp_wdat);
    end
    @(posedge clk); #1 mem_ack = 1'b1; mem_rdat = bus_rd;
    @(posedge clk); #1 mem_ack = 1'b0; data_req = 1'b0; mem_rdat = 32'h0;
    @(negedge clk);
    checks++;
    if (data_ready !== 1'b1 || data_error !== 1'b0 || inst_ready !== 1'b0 || (!wr && data_rdat !== exp_rd)) begin
      errors++;
      $display("FAIL %s_done: ready=%b err=%b iready=%b rdat=%h want 1 0 0 %h", name, data_ready, data_error,
               inst_ready, data_rdat, exp_rd);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_error(input string name, input logic [1:0] acc, input logic [31:0] addr);
    @(posedge clk); #1 data_req = 1'b1; data_wr = 1'b0; data_acc = acc; data_addr = addr;
    @(negedge clk);
    checks++;
    if (data_ready !== 1'b0 || mem_req !== 1'b0) begin
      errors++; $display("FAIL %s_early: ready=%b req=%b want 0 0", name, data_ready, mem_req);
    end
    @(posedge clk); #1 data_req = 1'b0;
    @(negedge clk);
    checks++;
    if (data_ready !== 1'b1 || data_error !== 1'b1 || data_rdat !== 32'd0 || mem_req !== 1'b0) begin
      errors++;
      $display("FAIL %s_resp: ready=%b err=%b rdat=%h req=%b want 1 1 0 0", name, data_ready, data_error, data_rdat, mem_req);
    end
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (data_ready !== 1'b0 || data_error !== 1'b0 || mem_req !== 1'b0) begin
      errors++; $display("FAIL %s_after: ready=%b err=%b req=%b want 0 0 0", name, data_ready, data_error, mem_req);
    end
  endtask

  task automatic test_burst();
    bit exp_d [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    bit seen;
    bit got_d;
    @(posedge clk); #1 inst_req = 1'b1; inst_addr = 32'h0000_4000;
    data_req = 1'b1; data_wr = 1'b0; data_acc = 2'b10; data_addr = 32'h0000_8000;
    for (int g = 0; g < 6; g++) begin
      seen = 1'b0;
      for (int c = 0; c < 20 && !seen; c++) begin
        @(negedge clk);
        if (mem_req) seen = 1'b1;
      end
      checks++;
      if (!seen) begin
        errors++; $display("FAIL burst_timeout: grant %0d never issued", g);
        break;
      end
      got_d = (mem_addr == 32'h0000_8000);
      checks++;
      if (got_d !== exp_d[g]) begin
        errors++; $display("FAIL burst_order: grant %0d data=%b want %b", g, got_d, exp_d[g]);
      end
      @(posedge clk); #1 mem_ack = 1'b1; mem_rdat = 32'h1234_0000 + 32'(g);
      @(posedge clk); #1 mem_ack = 1'b0;
      if (g == 5) begin inst_req = 1'b0; data_req = 1'b0; end
    end
    inst_req = 1'b0; data_req = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_simultaneous();
    @(posedge clk); #1 inst_req = 1'b1; inst_addr = 32'h0000_0500;
    data_req = 1'b1; data_wr = 1'b0; data_acc = 2'b10; data_addr = 32'h0000_3000;
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h0000_3000) begin
      errors++; $display("FAIL simul_first: req=%b addr=%h want 1 00003000", mem_req, mem_addr);
    end
    @(posedge clk); #1 mem_ack = 1'b1; mem_rdat = 32'hCAFE_F00D;
    @(posedge clk); #1 mem_ack = 1'b0; data_req = 1'b0;
    @(negedge clk);
    checks++;
    if (data_ready !== 1'b1 || data_rdat !== 32'hCAFE_F00D || inst_ready !== 1'b0) begin
      errors++; $display("FAIL simul_data_done: ready=%b rdat=%h iready=%b want 1 cafef00d 0", data_ready, data_rdat, inst_ready);
    end
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (mem_req !== 1'b0) begin errors++; $display("FAIL simul_idle: req=%b want 0", mem_req); end
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h0000_0500 || mem_wr !== 1'b0) begin
      errors++; $display("FAIL simul_inst_grant: req=%b addr=%h wr=%b want 1 00000500 0", mem_req, mem_addr, mem_wr);
    end
    @(posedge clk); #1 mem_ack = 1'b1; mem_rdat = 32'h1111_2222;
    @(posedge clk); #1 mem_ack = 1'b0; inst_req = 1'b0;
    @(negedge clk);
    checks++;
    if (inst_ready !== 1'b1 || inst_data !== 32'h1111_2222 || data_ready !== 1'b0) begin
      errors++; $display("FAIL simul_inst_done: ready=%b data=%h dready=%b want 1 11112222 0", inst_ready, inst_data, data_ready);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    bit spurious;
    @(posedge clk); #1 data_req = 1'b1; data_wr = 1'b0; data_acc = 2'b10; data_addr = 32'h0000_6000;
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (mem_req !== 1'b1) begin errors++; $display("FAIL rstmid_req: req=%b want 1", mem_req); end
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0; data_req = 1'b0;
    @(negedge clk);
    checks++;
    if (mem_req !== 1'b0 || mem_addr !== 32'd0 || data_ready !== 1'b0) begin
      errors++; $display("FAIL rstmid_drop: req=%b addr=%h ready=%b want 0 0 0", mem_req, mem_addr, data_ready);
    end
    @(posedge clk); #1;
    @(posedge clk); #1 mem_ack = 1'b1; mem_rdat = 32'h5555_AAAA;
    @(posedge clk); #1 mem_ack = 1'b0;
    spurious = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (data_ready || inst_ready || mem_req) spurious = 1'b1;
    end
    checks++;
    if (spurious !== 1'b0) begin errors++; $display("FAIL rstmid_stale_ack: activity=%b want 0", spurious); end
  endtask

  initial begin
    test_reset();
    test_inst_fetch(32'h0000_0104, 32'h0051_3023, 32'h0000_0104);
    test_data_access("byte_store", 1'b1, 2'b00, 32'h0000_2003, 32'h0000_00AB, 32'h0,
                     4'b1000, 32'hABAB_ABAB, 32'h0);
    test_data_access("half_load", 1'b0, 2'b01, 32'h0000_2002, 32'h0, 32'hBEEF_1234,
                     4'b1100, 32'h0, 32'h0000_BEEF);
    test_error("word_misaligned", 2'b10, 32'h0000_2002);
    test_data_access("byte_load", 1'b0, 2'b00, 32'h0000_2001, 32'h0, 32'h1122_3344,
                     4'b0010, 32'h0, 32'h0011_2233);
    test_error("access_invalid", 2'b11, 32'h0000_2000);
    test_data_access("half_store", 1'b1, 2'b01, 32'h0000_2000, 32'h1234_5678, 32'h0,
                     4'b0011, 32'h5678_5678, 32'h0);
    test_error("half_misaligned", 2'b01, 32'h0000_2001);
    test_data_access("word_store", 1'b1, 2'b10, 32'h0000_2004, 32'hCAFE_BABE, 32'h0,
                     4'b1111, 32'hCAFE_BABE, 32'h0);
    test_burst();
    test_simultaneous();
    test_reset_mid();
    test_inst_fetch(32'h0000_0703, 32'hDEAD_BEEF, 32'h0000_0700);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
